// File: rtl/branch_predictor_table.sv
// Bimodal/gshare direction predictor: a table of saturating counters initialised by a sweep
// after reset, with a one-cycle predict port and an independent resolved-outcome update port.
module branch_predictor_table #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned GHR_BITS   = 0,
  parameter int unsigned INIT_CTR   = 1,
  localparam int unsigned GhrW      = (GHR_BITS > 0) ? GHR_BITS : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  pred_valid,
  input  logic [31:0]           pred_pc,
  output logic                  pred_out_valid,
  output logic                  pred_taken,
  output logic [CTR_BITS-1:0]   pred_ctr,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken,
  input  logic                  ghr_clear,
  output logic [GhrW-1:0]       ghr
);

  localparam int unsigned Entries = 2 ** INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CtrMax  = '1;
  localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'(INIT_CTR);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [INDEX_BITS-1:0] ptr_q, ptr_d;
  logic [GhrW-1:0]       ghr_q, ghr_d;
  logic [GhrW:0]         ghr_shift;
  logic [CTR_BITS-1:0]   table_q [Entries];
  logic                  run;

  logic [CTR_BITS-1:0]   upd_cur, upd_new;
  logic [INDEX_BITS-1:0] pred_idx;
  logic [CTR_BITS-1:0]   pred_rd;

  logic                  pred_out_valid_q;
  logic                  pred_taken_q;
  logic [CTR_BITS-1:0]   pred_ctr_q;
  logic [INDEX_BITS-1:0] pred_index_q;

  logic                  unused_pc;
  assign unused_pc = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StInit;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state logic: the sweep advances one entry per cycle until the last one is written
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StInit: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = StRun;
      end
      StRun:  state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // Output logic
  always_comb begin
    run   = (state_q == StRun);
    ready = run;
  end

  always_comb begin
    upd_cur = table_q[upd_index];
    if (upd_taken) upd_new = (upd_cur == CtrMax) ? upd_cur : upd_cur + 1'b1;
    else           upd_new = (upd_cur == '0) ? upd_cur : upd_cur - 1'b1;
  end

  // Table contents have no reset; the sweep restores them
  always_ff @(posedge clk) begin
    if (!run)           table_q[ptr_q]     <= CtrInit;
    else if (upd_valid) table_q[upd_index] <= upd_new;
  end

  // Index uses the pre-shift history; same-index update is forwarded to the read
  always_comb begin
    pred_idx = pred_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_q);
    if (run && upd_valid && (upd_index == pred_idx)) pred_rd = upd_new;
    else                                             pred_rd = table_q[pred_idx];
  end

  always_comb begin
    ghr_shift = {ghr_q, upd_taken};
    ghr_d     = ghr_q;
    if (GHR_BITS == 0)         ghr_d = '0;
    else if (run && ghr_clear) ghr_d = '0;
    else if (run && upd_valid) ghr_d = ghr_shift[GhrW-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q            <= '0;
      pred_out_valid_q <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_ctr_q       <= '0;
      pred_index_q     <= '0;
    end else begin
      ghr_q            <= ghr_d;
      pred_out_valid_q <= run & pred_valid;
      if (run && pred_valid) begin
        pred_taken_q <= pred_rd[CTR_BITS-1];
        pred_ctr_q   <= pred_rd;
        pred_index_q <= pred_idx;
      end
    end
  end

  assign pred_out_valid = pred_out_valid_q;
  assign pred_taken     = pred_taken_q;
  assign pred_ctr       = pred_ctr_q;
  assign pred_index     = pred_index_q;
  assign ghr            = ghr_q;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Bench for branch_predictor_table: a bimodal and a gshare instance share stimulus and are
// checked every cycle against a table-of-integers model, plus directed literal expectations.
module tb_branch_predictor_table;

  logic        clk;
  logic        reset;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [3:0]  upd_index;
  logic        upd_taken;
  logic        ghr_clear;

  logic        rdy [2];
  logic        pov [2];
  logic        ptk [2];
  logic [1:0]  pctr [2];
  logic [3:0]  pidx [2];
  logic        ghr_b;
  logic [3:0]  ghr_g;

  int n_chk = 0;
  int n_fail = 0;
  bit started = 0;

  branch_predictor_table #(
    .INDEX_BITS(4), .CTR_BITS(2), .GHR_BITS(0), .INIT_CTR(1)
  ) dut_b (
    .clk(clk), .reset(reset), .ready(rdy[0]),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_out_valid(pov[0]), .pred_taken(ptk[0]), .pred_ctr(pctr[0]), .pred_index(pidx[0]),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .ghr_clear(ghr_clear), .ghr(ghr_b)
  );

  branch_predictor_table #(
    .INDEX_BITS(4), .CTR_BITS(2), .GHR_BITS(4), .INIT_CTR(1)
  ) dut_g (
    .clk(clk), .reset(reset), .ready(rdy[1]),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_out_valid(pov[1]), .pred_taken(ptk[1]), .pred_ctr(pctr[1]), .pred_index(pidx[1]),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .ghr_clear(ghr_clear), .ghr(ghr_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // Model: instance 0 has no history, instance 1 keeps a 4-bit history
  int mctr [2][16];
  int mghr [2];
  int mcnt;
  bit e_valid [2];
  int e_ctr [2];
  int e_idx [2];

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mcnt = 0;
        for (int k = 0; k < 2; k++) begin
          mghr[k] = 0; e_valid[k] = 0; e_ctr[k] = 0; e_idx[k] = 0;
        end
      end else if (mcnt < 16) begin
        mcnt++;
        if (mcnt == 16)
          for (int k = 0; k < 2; k++) for (int e = 0; e < 16; e++) mctr[k][e] = 1;
        for (int k = 0; k < 2; k++) e_valid[k] = 0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          int idx, c;
          idx = int'((pred_pc >> 2) & 32'hF) ^ mghr[k];
          if (upd_valid) begin
            c = mctr[k][upd_index];
            if (upd_taken) c = (c < 3) ? c + 1 : 3;
            else           c = (c > 0) ? c - 1 : 0;
            mctr[k][upd_index] = c;
          end
          e_valid[k] = pred_valid;
          if (pred_valid) begin
            e_ctr[k] = mctr[k][idx];
            e_idx[k] = idx;
          end
          if (k == 1) begin
            if (ghr_clear)      mghr[k] = 0;
            else if (upd_valid) mghr[k] = ((mghr[k] << 1) | int'(upd_taken)) & 15;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("ready%0d", k), rdy[k], (mcnt == 16) ? 1 : 0);
          chk($sformatf("out_valid%0d", k), pov[k], e_valid[k]);
          chk($sformatf("ctr%0d", k), pctr[k], e_ctr[k]);
          chk($sformatf("taken%0d", k), ptk[k], (e_ctr[k] >= 2) ? 1 : 0);
          chk($sformatf("index%0d", k), pidx[k], e_idx[k]);
        end
        chk("ghr_g", ghr_g, mghr[1]);
        chk("ghr_b", ghr_b, 0);
      end
    end
  end

  task automatic step(input bit pv, input logic [31:0] pc, input bit uv, input int ui,
                      input bit ut, input bit gc);
    pred_valid = pv; pred_pc = pc; upd_valid = uv; upd_index = ui[3:0];
    upd_taken = ut; ghr_clear = gc;
    @(posedge clk); #1;
    pred_valid = 0; upd_valid = 0; ghr_clear = 0;
  endtask

  int sat_up [4] = '{2, 3, 3, 3};
  int sat_dn [5] = '{2, 1, 0, 0, 0};

  initial begin
    pred_valid = 0; pred_pc = '0; upd_valid = 0; upd_index = '0; upd_taken = 0; ghr_clear = 0;
    reset = 0;
    #2 reset = 1;
    started = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", rdy[0], 0);
    chk("rst_ctr", pctr[0], 0);
    reset = 0;

    // Sweep of 16 entries
    repeat (15) begin @(posedge clk); #1; end
    chk("sweep_not_ready", rdy[0], 0);
    @(posedge clk); #1;
    chk("sweep_ready", rdy[0], 1);

    step(1, 32'h0000_0000, 0, 0, 0, 0);
    chk("init_ctr", pctr[0], 1);
    chk("init_taken", ptk[0], 0);

    // Saturation on idx 3
    step(1, 32'h0000_000C, 0, 0, 0, 0);
    chk("sat_start", pctr[0], 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 3, 1, 0);
      step(1, 32'h0000_000C, 0, 0, 0, 0);
      chk($sformatf("sat_up%0d", i), pctr[0], sat_up[i]);
    end
    chk("sat_up_taken", ptk[0], 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 3, 0, 0);
      step(1, 32'h0000_000C, 0, 0, 0, 0);
      chk($sformatf("sat_dn%0d", i), pctr[0], sat_dn[i]);
    end
    chk("sat_dn_taken", ptk[0], 0);

    // Same-cycle update and predict to idx 5
    step(1, 32'h0000_0014, 1, 5, 1, 0);
    chk("bypass_ctr", pctr[0], 2);
    chk("bypass_taken", ptk[0], 1);
    chk("bypass_index", pidx[0], 5);

    // History
    step(0, 0, 0, 0, 0, 1);
    chk("ghr_cleared", ghr_g, 0);
    step(0, 0, 1, 9, 1, 0);
    step(0, 0, 1, 9, 1, 0);
    step(0, 0, 1, 9, 0, 0);
    chk("ghr_0110", ghr_g, 6);
    step(1, 32'h0000_0040, 0, 0, 0, 0);
    chk("gshare_index", pidx[1], 6);
    chk("bimodal_index", pidx[0], 0);
    chk("gshare_ctr", pctr[1], 1);
    step(0, 0, 1, 2, 1, 1);
    chk("ghr_clear_prio", ghr_g, 0);

    // Reset mid-sweep with requests pulsed during init
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 32'h0000_000C, 1, 3, 1, 1);
      chk($sformatf("init_pov%0d", i), pov[0], 0);
      chk($sformatf("init_rdy%0d", i), rdy[1], 0);
    end
    chk("init_ghr", ghr_g, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    repeat (15) begin @(posedge clk); #1; end
    chk("resweep_not_ready", rdy[0], 0);
    @(posedge clk); #1;
    chk("resweep_ready", rdy[0], 1);
    for (int p = 0; p < 16; p++) begin
      step(1, 32'(p * 4), 0, 0, 0, 0);
      chk($sformatf("reinit_ctr%0d", p), pctr[0], 1);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
Parametrised bimodal/gshare branch direction predictor. A table of 2^INDEX_BITS saturating counters, each CTR_BITS wide, replaces the single 2-bit counter. Sits beside the fetch stage: fetch issues a predict lookup per branch PC, and the execute stage returns the resolved outcome on a separate update port. Optional global history register (GHR) XOR-folds into the index (gshare mode).

Parameters:
INDEX_BITS, 6, log2 of table entries (64 entries)
CTR_BITS, 2, counter width; legal 1..4
GHR_BITS, 0, global history length; 0 = pure bimodal, legal 0..INDEX_BITS
INIT_CTR, 1, counter value written to every entry during init sweep (weakly not-taken for CTR_BITS=2); must be < 2^CTR_BITS

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high
ready  output  1  high when table initialised and accepting requests
pred_valid  input  1  predict request this cycle
pred_pc  input  32  PC of branch instruction
pred_out_valid  output  1  registered prediction valid
pred_taken  output  1  predicted direction (counter MSB)
pred_ctr  output  CTR_BITS  counter value used
pred_index  output  INDEX_BITS  table index used; fetch carries it to execute
upd_valid  input  1  resolved-branch update this cycle
upd_index  input  INDEX_BITS  index returned by earlier pred_index
upd_taken  input  1  actual outcome
ghr_clear  input  1  synchronous clear of GHR (pipeline flush/context switch)
ghr  output  max(GHR_BITS,1)  current history, LSB newest; tied 0 when GHR_BITS=0

Behaviour:
- Reset (async): ready=0, pred_out_valid=0, pred_taken=0, pred_ctr=0, pred_index=0, GHR=0, sweep pointer=0, FSM -> INIT.
- FSM states INIT, RUN. INIT: one entry per cycle written with INIT_CTR, starting at pointer 0 on the first clock after reset deasserts. After the entry 2^INDEX_BITS-1 write, -> RUN; ready=1 from that edge. Sweep takes exactly 2^INDEX_BITS cycles. Reset asserted mid-sweep or in RUN restarts the sweep at 0.
- In INIT, pred_valid, upd_valid and ghr_clear are ignored; pred_out_valid stays 0.
- Index: idx = pred_pc[INDEX_BITS+1:2] XOR zero-extended GHR (GHR zero-extended on the MSB side). PC bits [1:0] are never used.
- Predict latency 1 cycle: pred_valid at edge N -> pred_out_valid=1 and pred_taken/pred_ctr/pred_index valid after edge N, for one cycle. When no request, pred_out_valid=0; other pred outputs hold their last value.
- Update: on upd_valid in RUN, entry[upd_index] <- min(ctr+1, 2^CTR_BITS-1) if upd_taken, else max(ctr-1, 0). Saturation holds at both ends with no wrap-around.
- Same-cycle predict and update to the same index: the prediction returns the post-update value (write-first bypass). Different indices are fully independent.
- GHR: on upd_valid in RUN, GHR <- {GHR[GHR_BITS-2:0], upd_taken} (non-speculative). ghr_clear takes priority over a same-cycle shift. The predict index in the same cycle uses the pre-shift GHR.
- Updates to an index never touch other entries. There is no handshake back-pressure; one predict plus one update per cycle is always accepted in RUN.
- Storage is a register array. The async reset acts only on control, GHR and outputs; table contents are restored by the sweep.

Test Plan:
- INDEX_BITS=4: deassert reset, count cycles -> ready rises exactly 16 cycles later; predict any PC -> pred_ctr=1, pred_taken=0.
- Saturation, CTR_BITS=2: 4 taken updates to idx 3 -> predict PC 0x0C gives ctr 1->2->3->3, pred_taken=1; then 5 not-taken -> ctr 0, stays 0.
- Bypass: in the same cycle, upd_valid idx 5 taken (ctr 1) and pred_valid PC 0x14 -> next cycle pred_ctr=2, pred_taken=1.
- gshare, GHR_BITS=4: updates taken,taken,not-taken -> ghr=4'b0110; predict PC 0x40 (bits=0) -> pred_index=6; ghr_clear with upd_valid -> ghr=0.
- Reset mid-sweep at cycle 8 -> ready stays 0; full 16-cycle sweep restarts; earlier trained entries read INIT_CTR.
- In INIT, pulse pred_valid/upd_valid -> pred_out_valid stays 0; after ready, all entries read INIT_CTR.
